rtio_fifo_write_arbiter: RTL and testbench

- Write-side controller for the RTIO asynchronous event FIFO. It shares one FIFO write port among NUM_REQ requesters using round-robin arbitration with packet locking.
- It owns the write pointer: a binary counter plus its gray image, which it supplies to the FIFO RAM and to the cross-domain pointer path.
- It computes full and fill level against the read pointer. The read pointer arrives already gray-synchronized into this clock domain.

---
 rtl/rtio_fifo_write_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_rtio_fifo_write_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtio_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// rtio_fifo_write_arbiter
//
// Write-side controller for the RTIO asynchronous event FIFO. NUM_REQ
// requesters share the single FIFO write port through round-robin
// arbitration. A multi-beat packet locks the port until its last beat. The
// block owns the write pointer (binary plus gray image). It derives full and
// the fill level from the read pointer, which arrives already synchronized
// into this clock domain.
//
// Ports
//   i_clk_wr          write-domain clock
//   i_reset_wr        synchronous active-high reset
//   i_enable          when low, no beat is accepted
//   i_req_valid       per-requester beat valid
//   i_req_last        per-requester last beat of packet
//   i_req_data        requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready       per-requester accept (at most one bit high)
//   i_rd_gray_synced  read pointer, gray coded, synchronized to i_clk_wr
//   o_wr_en / o_wr_ce RAM write strobe / pointer-advance strobe (identical)
//   o_wr_addr         RAM write address
//   o_wr_data         RAM write data
//   o_wr_gray         registered gray write pointer for the read domain
//   o_full            FIFO full
//   o_level           registered fill count
//   o_grant_id        current or most recent grantee
//   o_locked          high while a packet holds the port
// ---------------------------------------------------------------------------
module rtio_fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int LENGTH     = 8
) (
  input  logic                          i_clk_wr,
  input  logic                          i_reset_wr,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [LENGTH-1:0]             i_rd_gray_synced,
  output logic                          o_wr_en,
  output logic                          o_wr_ce,
  output logic [LENGTH-2:0]             o_wr_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [LENGTH-1:0]             o_wr_gray,
  output logic                          o_full,
  output logic [LENGTH-1:0]             o_level,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_locked
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = LENGTH - 1;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDW-1:0]          r_last_grant;
  logic [IDW-1:0]          w_last_grant_next;
  logic [IDW-1:0]          r_lock_id;
  logic [IDW-1:0]          w_lock_id_next;
  logic [IDW-1:0]          r_grant_id;

  logic [LENGTH-1:0]       r_wr_bin;
  logic [LENGTH-1:0]       r_wr_gray;
  logic [LENGTH-1:0]       r_level;
  logic                    r_wr_en;
  logic [AW-1:0]           r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;

  logic [LENGTH-1:0]       w_rd_bin;
  logic [LENGTH-1:0]       w_wr_bin_next;
  logic                    w_full;
  logic [IDW-1:0]          w_sel;
  logic                    w_sel_ok;
  logic [NUM_REQ-1:0]      w_ready;
  logic                    w_accept;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_rd_bin = '0;
    for (int k = 0; k < LENGTH; k++) begin
      w_rd_bin[k] = ^(i_rd_gray_synced >> k);
    end
  end

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  // In gray code this means the top two bits differ and the rest match. Only
  // registers and the synchronized read pointer feed this, never req_*.
  assign w_full = (r_wr_gray == {~i_rd_gray_synced[LENGTH-1:LENGTH-2],
                                 i_rd_gray_synced[LENGTH-3:0]});

  // Pick the candidate requester. A locked packet keeps its owner and is
  // offered ready even while its valid is low. When idle, the search starts
  // one past the last grantee. It runs downwards so the nearest valid
  // requester is written last and wins.
  always_comb begin
    w_sel    = r_lock_id;
    w_sel_ok = 1'b0;
    if (r_state == S_LOCKED) begin
      w_sel    = r_lock_id;
      w_sel_ok = 1'b1;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (i_req_valid[IDW'((int'(r_last_grant) + k) % NUM_REQ)]) begin
          w_sel    = IDW'((int'(r_last_grant) + k) % NUM_REQ);
          w_sel_ok = 1'b1;
        end
      end
    end
  end

  // One-hot ready toward the selected requester only.
  always_comb begin
    w_ready = '0;
    if (i_enable && !w_full && w_sel_ok) begin
      w_ready[w_sel] = 1'b1;
    end
  end

  assign w_accept      = |(i_req_valid & w_ready);
  assign w_sel_last    = i_req_last[w_sel];
  assign w_sel_data    = i_req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_wr_bin_next = r_wr_bin + LENGTH'(w_accept);

  // Arbitration next-state. A last beat always returns to IDLE and moves
  // round-robin priority. A non-last beat in IDLE opens a packet lock.
  always_comb begin
    w_state_next      = r_state;
    w_lock_id_next    = r_lock_id;
    w_last_grant_next = r_last_grant;
    if (w_accept) begin
      if (w_sel_last) begin
        w_state_next      = S_IDLE;
        w_last_grant_next = w_sel;
      end else if (r_state == S_IDLE) begin
        w_state_next   = S_LOCKED;
        w_lock_id_next = w_sel;
      end
    end
  end

  // Arbitration state register. Reset drops any packet lock and gives
  // requester 0 first priority.
  always_ff @(posedge i_clk_wr) begin
    if (i_reset_wr) begin
      r_state      <= S_IDLE;
      r_lock_id    <= '0;
      r_last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_next;
      r_lock_id    <= w_lock_id_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  // Write pipeline and pointer. The RAM write appears one cycle after the
  // accept, using the pointer value from before the increment. Level is
  // taken from the post-increment pointer, so it already includes this beat.
  always_ff @(posedge i_clk_wr) begin
    if (i_reset_wr) begin
      r_wr_bin   <= '0;
      r_wr_gray  <= '0;
      r_level    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
    end else begin
      r_wr_bin  <= w_wr_bin_next;
      r_wr_gray <= w_wr_bin_next ^ (w_wr_bin_next >> 1);
      r_level   <= w_wr_bin_next - w_rd_bin;
      r_wr_en   <= w_accept;
      if (w_accept) begin
        r_wr_addr  <= r_wr_bin[AW-1:0];
        r_wr_data  <= w_sel_data;
        r_grant_id <= w_sel;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_wr_en     = r_wr_en;
  assign o_wr_ce     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_wr_gray   = r_wr_gray;
  assign o_full      = w_full;
  assign o_level     = r_level;
  assign o_grant_id  = r_grant_id;
  assign o_locked    = (r_state == S_LOCKED);

endmodule

// File: tb/tb_rtio_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rtio_fifo_write_arbiter
//
// Bench for rtio_fifo_write_arbiter with NUM_REQ=4, DATA_WIDTH=64, LENGTH=4.
// A behavioural model predicts grants. Every accepted beat is queued as an
// {addr, data} pair. The pair is retired when the RAM write strobe shows up.
// ---------------------------------------------------------------------------
module tb_rtio_fifo_write_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int LEN = 4;
  localparam int MSK = (1 << LEN) - 1;

  logic             clk = 1'b0;
  logic             resetWr;
  logic             enable;
  logic [NR-1:0]    reqValid;
  logic [NR-1:0]    reqLast;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0]    reqReady;
  logic [LEN-1:0]   rdGray;
  logic             wrEn;
  logic             wrCe;
  logic [LEN-2:0]   wrAddr;
  logic [DW-1:0]    wrData;
  logic [LEN-1:0]   wrGray;
  logic             full;
  logic [LEN-1:0]   level;
  logic [1:0]       grantId;
  logic             locked;

  logic [DW-1:0]    dataWord [NR];

  int nCompared   = 0;
  int nMismatched = 0;

  logic [LEN+DW-2:0] sb[$];

  int          mWrBin, mLastGrant, mLockId, mSel, cycleNo;
  bit          mLocked, mAccept, expFull, sampFull;
  logic [NR-1:0] expReady, sampReady;
  int          expLevel, expGrant;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = dataWord[i];
  end

  rtio_fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .i_clk_wr(clk), .i_reset_wr(resetWr), .i_enable(enable),
    .i_req_valid(reqValid), .i_req_last(reqLast), .i_req_data(reqData),
    .o_req_ready(reqReady), .i_rd_gray_synced(rdGray),
    .o_wr_en(wrEn), .o_wr_ce(wrCe), .o_wr_addr(wrAddr), .o_wr_data(wrData),
    .o_wr_gray(wrGray), .o_full(full), .o_level(level),
    .o_grant_id(grantId), .o_locked(locked)
  );

  function automatic logic [LEN-1:0] toGray(input int b);
    logic [LEN-1:0] v;
    v = LEN'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int fromGray(input logic [LEN-1:0] g);
    logic [LEN-1:0] b;
    b[LEN-1] = g[LEN-1];
    for (int i = LEN - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  // Retire one queued beat whenever the RAM strobes fire.
  always @(posedge clk) begin
    logic [LEN+DW-2:0] exp;
    #1;
    if (wrEn === 1'b1 || wrCe === 1'b1) begin
      nCompared++;
      if (sb.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_write: got wr_en=%b wr_ce=%b addr=%0d, required no write", wrEn, wrCe, wrAddr);
      end else begin
        exp = sb.pop_front();
        if ({wrEn, wrCe, wrAddr, wrData} !== {2'b11, exp}) begin
          nMismatched++;
          $display("[TB] FAIL write_beat: got en=%b ce=%b addr=%0d data=%h, required en=1 ce=1 addr=%0d data=%h",
                   wrEn, wrCe, wrAddr, wrData, exp[LEN+DW-2:DW], exp[DW-1:0]);
        end
      end
    end
  end

  // One clock of stimulus. Ready and full are captured at the falling edge.
  // The model advances on the rising edge.
  task automatic tick();
    int rdBin, idx;
    bit found;
    @(negedge clk);
    sampReady = reqReady;
    sampFull  = full;
    rdBin     = fromGray(rdGray);
    expFull   = (((mWrBin - rdBin) & MSK) == (1 << (LEN - 1)));
    expReady  = '0;
    mAccept   = 1'b0;
    if (!resetWr) begin
      found = mLocked;
      mSel  = mLockId;
      if (!mLocked) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (mLastGrant + k) % NR;
          if (!found && reqValid[idx[1:0]]) begin
            found = 1'b1;
            mSel  = idx;
          end
        end
      end
      if (enable && !expFull && found) expReady[mSel[1:0]] = 1'b1;
      mAccept = expReady[mSel[1:0]] && reqValid[mSel[1:0]];
      if (mAccept) sb.push_back({3'(mWrBin), dataWord[mSel[1:0]]});
    end
    @(posedge clk);
    if (resetWr) begin
      mWrBin = 0; mLastGrant = NR - 1; mLocked = 1'b0; mLockId = 0;
      expGrant = 0; expLevel = 0;
      sb.delete();
    end else begin
      if (mAccept) begin
        mWrBin   = (mWrBin + 1) & MSK;
        expGrant = mSel;
        if (reqLast[mSel[1:0]]) begin
          mLocked    = 1'b0;
          mLastGrant = mSel;
        end else if (!mLocked) begin
          mLocked = 1'b1;
          mLockId = mSel;
        end
      end
      expLevel = (mWrBin - rdBin) & MSK;
    end
    #2;
    cycleNo++;
    for (int i = 0; i < NR; i++) dataWord[i] = {16'hCAFE, 16'(i), 32'(cycleNo)};
  endtask

  task automatic test_reset();
    resetWr = 1'b1; enable = 1'b1; reqValid = '0; reqLast = '0; rdGray = '0;
    tick(); tick();
    nCompared += 9;
    if (wrEn !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset_wr_en: got %b want 0", wrEn); end
    if (wrCe !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset_wr_ce: got %b want 0", wrCe); end
    if (wrAddr !== '0)    begin nMismatched++; $display("[TB] FAIL reset_wr_addr: got %0d want 0", wrAddr); end
    if (wrData !== '0)    begin nMismatched++; $display("[TB] FAIL reset_wr_data: got %h want 0", wrData); end
    if (wrGray !== '0)    begin nMismatched++; $display("[TB] FAIL reset_wr_gray: got %b want 0000", wrGray); end
    if (level !== '0)     begin nMismatched++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
    if (locked !== 1'b0)  begin nMismatched++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
    if (grantId !== '0)   begin nMismatched++; $display("[TB] FAIL reset_grant_id: got %0d want 0", grantId); end
    if (full !== 1'b0)    begin nMismatched++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    resetWr = 1'b0;
  endtask

  task automatic test_round_robin();
    reqValid = '1; reqLast = '1; rdGray = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      nCompared += 2;
      if (sampReady !== 4'(1 << (k % 4))) begin
        nMismatched++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", k, sampReady, 4'(1 << (k % 4)));
      end
      if (grantId !== 2'(k % 4)) begin
        nMismatched++; $display("[TB] FAIL rr_grant[%0d]: got %0d want %0d", k, grantId, k % 4);
      end
    end
    tick();
    nCompared += 3;
    if (sampReady !== '0) begin nMismatched++; $display("[TB] FAIL full_ready: got %b want 0000", sampReady); end
    if (sampFull !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_flag: got %b want 1", sampFull); end
    if (level !== 4'd8)   begin nMismatched++; $display("[TB] FAIL full_level: got %0d want 8", level); end
  endtask

  task automatic test_full_release();
    rdGray = 4'b0001;
    tick();
    nCompared += 4;
    if (sampFull !== 1'b0)      begin nMismatched++; $display("[TB] FAIL release_full: got %b want 0", sampFull); end
    if (sampReady !== 4'b0001)  begin nMismatched++; $display("[TB] FAIL release_ready: got %b want 0001", sampReady); end
    if (full !== 1'b1)          begin nMismatched++; $display("[TB] FAIL refull: got %b want 1", full); end
    if (level !== 4'd8)         begin nMismatched++; $display("[TB] FAIL release_level: got %0d want 8", level); end
    tick();
    nCompared++;
    if (sampReady !== '0) begin nMismatched++; $display("[TB] FAIL refull_ready: got %b want 0000", sampReady); end
    reqValid = '0; rdGray = toGray(mWrBin);
    tick();
    nCompared++;
    if (level !== 4'd0) begin nMismatched++; $display("[TB] FAIL drained_level: got %0d want 0", level); end
  endtask

  task automatic test_packet_lock();
    reqValid = 4'b1101; reqLast = 4'b1001;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) reqLast = 4'b1101;
      tick();
      nCompared += 2;
      if (sampReady !== 4'b0100) begin nMismatched++; $display("[TB] FAIL pkt_ready[%0d]: got %b want 0100", b, sampReady); end
      if (locked !== (b != 2))   begin nMismatched++; $display("[TB] FAIL pkt_locked[%0d]: got %b want %b", b, locked, b != 2); end
    end
    tick();
    nCompared += 2;
    if (sampReady !== 4'b1000) begin nMismatched++; $display("[TB] FAIL post_pkt_ready3: got %b want 1000", sampReady); end
    if (grantId !== 2'd3)      begin nMismatched++; $display("[TB] FAIL post_pkt_grant3: got %0d want 3", grantId); end
    tick();
    nCompared += 2;
    if (sampReady !== 4'b0001) begin nMismatched++; $display("[TB] FAIL post_pkt_ready0: got %b want 0001", sampReady); end
    if (grantId !== 2'd0)      begin nMismatched++; $display("[TB] FAIL post_pkt_grant0: got %0d want 0", grantId); end
    reqValid = '0; rdGray = toGray(mWrBin);
    tick();
  endtask

  task automatic test_enable_stall();
    reqValid = 4'b0011; reqLast = 4'b0001;
    tick();
    nCompared += 2;
    if (sampReady !== 4'b0010) begin nMismatched++; $display("[TB] FAIL stall_start_ready: got %b want 0010", sampReady); end
    if (locked !== 1'b1)       begin nMismatched++; $display("[TB] FAIL stall_start_locked: got %b want 1", locked); end
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      nCompared += 3;
      if (sampReady !== '0) begin nMismatched++; $display("[TB] FAIL stall_ready[%0d]: got %b want 0000", c, sampReady); end
      if (wrEn !== 1'b0)    begin nMismatched++; $display("[TB] FAIL stall_wr_en[%0d]: got %b want 0", c, wrEn); end
      if (locked !== 1'b1)  begin nMismatched++; $display("[TB] FAIL stall_locked[%0d]: got %b want 1", c, locked); end
    end
    enable = 1'b1; reqLast = 4'b0011;
    tick();
    nCompared += 4;
    if (sampReady !== 4'b0010) begin nMismatched++; $display("[TB] FAIL resume_ready: got %b want 0010", sampReady); end
    if (grantId !== 2'd1)      begin nMismatched++; $display("[TB] FAIL resume_grant: got %0d want 1", grantId); end
    if (locked !== 1'b0)       begin nMismatched++; $display("[TB] FAIL resume_locked: got %b want 0", locked); end
    if (wrEn !== 1'b1)         begin nMismatched++; $display("[TB] FAIL resume_wr_en: got %b want 1", wrEn); end
    reqValid = '0;
  endtask

  task automatic test_reset_midpacket();
    rdGray = toGray(mWrBin);
    reqValid = 4'b0100; reqLast = 4'b0000;
    tick();
    nCompared++;
    if (locked !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_locked: got %b want 1", locked); end
    resetWr = 1'b1; reqValid = '1; reqLast = '1; rdGray = '0;
    tick();
    resetWr = 1'b0;
    nCompared += 6;
    if (wrGray !== '0)   begin nMismatched++; $display("[TB] FAIL mid_reset_gray: got %b want 0000", wrGray); end
    if (level !== '0)    begin nMismatched++; $display("[TB] FAIL mid_reset_level: got %0d want 0", level); end
    if (locked !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_reset_locked: got %b want 0", locked); end
    if (wrEn !== 1'b0)   begin nMismatched++; $display("[TB] FAIL mid_reset_wr_en: got %b want 0", wrEn); end
    if (grantId !== '0)  begin nMismatched++; $display("[TB] FAIL mid_reset_grant: got %0d want 0", grantId); end
    if ({wrAddr, wrData} !== '0) begin nMismatched++; $display("[TB] FAIL mid_reset_addr_data: got %0d/%h want 0/0", wrAddr, wrData); end
    tick();
    nCompared++;
    if (sampReady !== 4'b0001) begin nMismatched++; $display("[TB] FAIL mid_reset_first: got %b want 0001", sampReady); end
  endtask

  task automatic test_drain_wrap();
    int wAbs;
    wAbs = 1;
    reqValid = '1; reqLast = '1;
    for (int n = 0; n < 40; n++) begin
      rdGray = (wAbs >= 2) ? toGray((wAbs - 2) & MSK) : '0;
      tick();
      wAbs++;
      nCompared += 4;
      if (sampReady !== expReady || sampReady === '0) begin
        nMismatched++; $display("[TB] FAIL drain_ready[%0d]: got %b want %b", n, sampReady, expReady);
      end
      if (wrGray !== toGray(wAbs & MSK)) begin
        nMismatched++; $display("[TB] FAIL drain_gray[%0d]: got %b want %b", n, wrGray, toGray(wAbs & MSK));
      end
      if ($countones(wrGray ^ toGray((wAbs - 1) & MSK)) != 1) begin
        nMismatched++; $display("[TB] FAIL drain_gray_step[%0d]: got %b after %b, want one bit change", n, wrGray, toGray((wAbs - 1) & MSK));
      end
      if (level !== LEN'(expLevel)) begin
        nMismatched++; $display("[TB] FAIL drain_level[%0d]: got %0d want %0d", n, level, expLevel);
      end
      if (wAbs == 16) begin
        nCompared++;
        if (wrGray !== 4'b0000) begin nMismatched++; $display("[TB] FAIL wrap_gray: got %b want 0000", wrGray); end
      end
    end
    reqValid = '0;
    tick();
    nCompared++;
    if (sb.size() != 0) begin nMismatched++; $display("[TB] FAIL pending_writes: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    mWrBin = 0; mLastGrant = NR - 1; mLockId = 0; mLocked = 1'b0; cycleNo = 0;
    expGrant = 0; expLevel = 0;
    for (int i = 0; i < NR; i++) dataWord[i] = {16'hCAFE, 16'(i), 32'(0)};
    resetWr = 1'b1; enable = 1'b0; reqValid = '0; reqLast = '0; rdGray = '0;
    #2;
    test_reset();
    test_round_robin();
    test_full_release();
    test_packet_lock();
    test_enable_stall();
    test_reset_midpacket();
    test_drain_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
